irq_controller: RTL

- Parametrised, memory-mapped interrupt controller that replaces the fixed 8-line priority chain in the top-level glue logic.
- Latches up to NUM_IRQ request lines (per-line edge or level mode) into a pending register, masks them and resolves priority (index 0 highest).
- Drives the CPU INT line and supplies the vector on the data bus during the intack handshake.
- Tracks in-service interrupts for nesting and exposes pending/mask/mode/EOI registers on the CPU address space.

---
 rtl/irq_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// Memory-mapped prioritised interrupt controller: per-line edge/level latching, masking,
// in-service nesting and an intack handshake that supplies the vector.
module irq_controller #(
  parameter int unsigned       NUM_IRQ     = 8,
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'h230,
  parameter int unsigned       VECTOR_BASE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [ADDR_W-1:0]  address,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               memwt,
  input  logic               intack,
  output logic               sel,
  output logic [DATA_W-1:0]  rd_data,
  output logic               int_out,
  output logic [DATA_W-1:0]  vector
);

  localparam int unsigned IW = $clog2(NUM_IRQ + 1);
  localparam logic [IW-1:0] NoIrq = IW'(NUM_IRQ);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] isr_q, isr_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] prev_q;
  logic [DATA_W-1:0]  vec_q, vec_idle;
  logic               int_q, int_d;

  logic [ADDR_W-1:0]  addr_off;
  logic [1:0]         off;
  logic               wr_en;
  logic [NUM_IRQ-1:0] req, ack_oh, w1c, eoi_clr, edge_set;
  logic [IW-1:0]      winner, ceiling;
  logic               req_any, ack;

  // Index of the lowest set bit, or NoIrq when the vector is empty.
  function automatic logic [IW-1:0] lowest(input logic [NUM_IRQ-1:0] v);
    logic [IW-1:0] idx;
    idx = NoIrq;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (v[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  assign addr_off = address - BASE_ADDR;
  assign sel      = (address >= BASE_ADDR) && (addr_off[ADDR_W-1:2] == '0);
  assign off      = addr_off[1:0];
  assign wr_en    = memwt && sel;

  always_comb begin
    req      = pend_q & mask_q;
    req_any  = |req;
    winner   = lowest(req);
    ceiling  = lowest(isr_q);
    ack      = (state_q == StIdle) && intack;
    // Isolate the lowest set request bit (the winner) as a one-hot mask.
    ack_oh   = ack ? (req & (~req + 1'b1)) : '0;
    edge_set = irq_in & ~prev_q;
    w1c      = (wr_en && off == 2'd0) ? wr_data[NUM_IRQ-1:0] : '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      eoi_clr[i] = wr_en && (off == 2'd3) && (wr_data == DATA_W'(i));
    end

    // Edge lines: set beats clear. Level lines simply mirror the input.
    pend_d = (mode_q & (edge_set | (pend_q & ~(w1c | ack_oh)))) | (~mode_q & irq_in);
    isr_d  = (isr_q & ~eoi_clr) | ack_oh;
    mask_d = (wr_en && off == 2'd1) ? wr_data[NUM_IRQ-1:0] : mask_q;
    mode_d = (wr_en && off == 2'd2) ? wr_data[NUM_IRQ-1:0] : mode_q;

    state_d = state_q;
    unique case (state_q)
      StIdle: if (intack) state_d = StHold;
      StHold: if (!intack) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // ceiling is NoIrq when nothing is in service, so the compare covers both cases.
    int_d    = (state_d == StIdle) && req_any && (winner < ceiling);
    vec_idle = DATA_W'(VECTOR_BASE) + DATA_W'(winner);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      isr_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      prev_q  <= '0;
      vec_q   <= DATA_W'(VECTOR_BASE + NUM_IRQ);
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      prev_q  <= irq_in;
      int_q   <= int_d;
      if (ack) vec_q <= vec_idle;
    end
  end

  assign int_out = int_q;
  assign vector  = (state_q == StHold) ? vec_q : vec_idle;

  always_comb begin
    rd_data = '0;
    if (sel) begin
      unique case (off)
        2'd0: rd_data[NUM_IRQ-1:0] = pend_q;
        2'd1: rd_data[NUM_IRQ-1:0] = mask_q;
        2'd2: rd_data[NUM_IRQ-1:0] = mode_q;
        2'd3: rd_data[NUM_IRQ-1:0] = isr_q;
        default: rd_data = '0;
      endcase
    end
  end

endmodule
